// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier sequencer that borrows the shared 32-bit ALU.
// It issues one ALU op per cycle and returns the low 32 product bits, a sticky overflow flag and a done pulse.
module alu_mul_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        ovf,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_sel,
    input  logic [31:0] alu_f,
    input  logic        alu_ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SLL = 3'b101;

    logic [1:0]  state;
    logic [31:0] p;
    logic [31:0] m;
    logic [31:0] q;
    logic [5:0]  cnt;
    logic [31:0] q_next;
    logic [5:0]  cnt_next;

    // Request handshake: start is taken only on an edge where busy is low;
    // while busy (including the done cycle) start and the operands are ignored.
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign q_next   = {1'b0, q[31:1]};
    assign cnt_next = cnt + 6'd1;

    always_comb begin
        alu_sel = SEL_ADD;
        alu_a   = 32'd0;
        alu_b   = 32'd0;
        case (state)
            S_ADD: begin
                alu_a = p;
                alu_b = m;
            end
            S_SHIFT: begin
                alu_sel = SEL_SLL;
                alu_a   = m;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            p      <= 32'd0;
            m      <= 32'd0;
            q      <= 32'd0;
            cnt    <= 6'd0;
            result <= 32'd0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        p   <= 32'd0;
                        m   <= op_a;
                        q   <= op_b;
                        cnt <= 6'd0;
                        ovf <= 1'b0;
                        if (EARLY_EXIT && (op_b == 32'd0)) begin
                            state  <= S_DONE;
                            result <= 32'd0;
                        end else if (op_b[0]) begin
                            state <= S_ADD;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_ADD: begin
                    p     <= alu_f;
                    ovf   <= ovf | alu_ovf;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    m   <= alu_f;
                    q   <= q_next;
                    cnt <= cnt_next;
                    // P is final here: the last ADD always precedes this SHIFT.
                    if ((cnt_next == 6'd32) || (EARLY_EXIT && (q_next == 32'd0))) begin
                        state  <= S_DONE;
                        result <= p;
                    end else if (q_next[0]) begin
                        state <= S_ADD;
                    end else begin
                        state <= S_SHIFT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: one early-exit and one full-iteration instance,
// each wired to a behavioural ALU (add / shift-left-by-one).
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          tests = 0;
    int          failed = 0;

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [31:0] op_a0 = '0, op_b0 = '0, op_a1 = '0, op_b1 = '0;
    logic        busy0, done0, ovf0, busy1, done1, ovf1;
    logic [31:0] result0, result1;
    logic [31:0] alu_a0, alu_b0, alu_f0, alu_a1, alu_b1, alu_f1;
    logic [2:0]  alu_sel0, alu_sel1;
    logic        alu_ovf0, alu_ovf1;
    logic [2:0]  exp_q[$];

    always #5 clk = ~clk;

    alu_mul_seq #(.EARLY_EXIT(1'b1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .op_a(op_a0), .op_b(op_b0),
        .busy(busy0), .done(done0), .result(result0), .ovf(ovf0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_sel(alu_sel0),
        .alu_f(alu_f0), .alu_ovf(alu_ovf0)
    );

    alu_mul_seq #(.EARLY_EXIT(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1),
        .busy(busy1), .done(done1), .result(result1), .ovf(ovf1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
        .alu_f(alu_f1), .alu_ovf(alu_ovf1)
    );

    // Reference ALU: 000 = add with signed overflow, 101 = shift left by one.
    always_comb begin
        alu_f0   = 32'hDEAD_BEEF;
        alu_ovf0 = 1'b0;
        if (alu_sel0 == 3'b000) begin
            alu_f0   = alu_a0 + alu_b0;
            alu_ovf0 = (alu_a0[31] == alu_b0[31]) && (alu_f0[31] != alu_a0[31]);
        end else if (alu_sel0 == 3'b101) begin
            alu_f0 = {alu_a0[30:0], 1'b0};
        end
    end

    always_comb begin
        alu_f1   = 32'hDEAD_BEEF;
        alu_ovf1 = 1'b0;
        if (alu_sel1 == 3'b000) begin
            alu_f1   = alu_a1 + alu_b1;
            alu_ovf1 = (alu_a1[31] == alu_b1[31]) && (alu_f1[31] != alu_a1[31]);
        end else if (alu_sel1 == 3'b101) begin
            alu_f1 = {alu_a1[30:0], 1'b0};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input int inst);
        return (inst == 0) ? done0 : done1;
    endfunction

    // Runs one multiply on the chosen instance and checks latency, result, ovf and the done pulse width.
    task automatic run_op(input int inst, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic eo, input int elat, input string tag);
        int lat;
        @(negedge clk);
        if (inst == 0) begin start0 = 1'b1; op_a0 = a; op_b0 = b; end
        else           begin start1 = 1'b1; op_a1 = a; op_b1 = b; end
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        lat = 1;
        while (!get_done(inst) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_result"}, (inst == 0) ? result0 : result1, er);
        check({tag, "_ovf"}, 32'((inst == 0) ? ovf0 : ovf1), 32'(eo));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(get_done(inst)), 32'd0);
    endtask

    initial begin
        int done_seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_result", result0, 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        check("rst_alu_sel", 32'(alu_sel0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic 3*5 with ALU sequence ADD, SHIFT, SHIFT, ADD, SHIFT
        exp_q = '{3'b000, 3'b101, 3'b101, 3'b000, 3'b101};
        @(negedge clk);
        start0 = 1'b1; op_a0 = 32'd3; op_b0 = 32'd5;
        @(posedge clk); #1;
        start0 = 1'b0;
        check("seq_first_alu_a", alu_a0, 32'd0);
        check("seq_first_alu_b", alu_b0, 32'd3);
        while (exp_q.size() > 0) begin
            check("seq_alu_sel", 32'(alu_sel0), 32'(exp_q.pop_front()));
            check("seq_no_early_done", 32'(done0), 32'd0);
            @(posedge clk); #1;
        end
        check("seq_done", 32'(done0), 32'd1);
        check("seq_result", result0, 32'd15);
        check("seq_ovf", 32'(ovf0), 32'd0);
        @(posedge clk); #1;
        check("seq_idle", 32'(busy0), 32'd0);

        // Zero multiplier on both instances, and 3*5 without early exit
        run_op(0, 32'h1234, 32'd0, 32'd0, 1'b0, 1, "zero_ee1");
        run_op(1, 32'h1234, 32'd0, 32'd0, 1'b0, 33, "zero_ee0");
        run_op(1, 32'd3, 32'd5, 32'd15, 1'b0, 35, "basic_ee0");

        // Signed-add overflow, then cleared by the next operation
        run_op(0, 32'h3000_0000, 32'd3, 32'h9000_0000, 1'b1, 5, "ovf");
        run_op(0, 32'd2, 32'd2, 32'd4, 1'b0, 4, "ovf_clear");

        // Maximum latency
        run_op(0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 65, "max_ee1");
        run_op(1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 65, "max_ee0");

        // start held with changing operands through the DONE cycle; only 6*7 is taken
        @(negedge clk);
        start0 = 1'b1; op_a0 = 32'd6; op_b0 = 32'd7;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            op_a0 = 32'd100 + 32'(k); op_b0 = 32'd9 + 32'(k);
            @(posedge clk); #1;
        end
        check("hold_done", 32'(done0), 32'd1);
        check("hold_result", result0, 32'd42);
        @(negedge clk);
        op_a0 = 32'd9; op_b0 = 32'd9;
        @(posedge clk); #1;
        check("done_start_ignored", 32'(busy0), 32'd0);
        check("done_result_held", result0, 32'd42);
        @(negedge clk);
        op_a0 = 32'd5; op_b0 = 32'd3;
        @(posedge clk); #1;
        start0 = 1'b0;
        check("idle_start_accepted", 32'(busy0), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("idle_start_done", 32'(done0), 32'd1);
        check("idle_start_result", result0, 32'd15);

        // Reset three cycles into 7*0xFF aborts without a done pulse
        repeat (2) @(posedge clk);
        @(negedge clk);
        start0 = 1'b1; op_a0 = 32'd7; op_b0 = 32'hFF;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_done", 32'(done0), 32'd0);
        check("abort_result", result0, 32'd0);
        check("abort_ovf", 32'(ovf0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done0) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
